// File: rtl/csr_bank_pkg.sv
// Shared types for the csr_bank register bank.
// Request/response codes match every peripheral behind the memory arbiter.
package csr_bank_pkg;

  localparam int ADDR_W      = 32;
  localparam int WORD_W      = 32;
  localparam int LANE_N      = WORD_W / 8;
  localparam int MEM_COUNT_W = 2;
  localparam int MEM_CODE_W  = 3;

  typedef enum logic [MEM_COUNT_W-1:0] {
    MEM_COUNT_NONE = 2'd0,
    MEM_COUNT_BYTE = 2'd1,
    MEM_COUNT_HALF = 2'd2,
    MEM_COUNT_WORD = 2'd3
  } mem_count_e;

  typedef enum logic [MEM_CODE_W-1:0] {
    MEM_CODE_INVALID       = 3'd0,
    MEM_CODE_READ          = 3'd1,
    MEM_CODE_WRITE         = 3'd2,
    MEM_CODE_MISALIGNED    = 3'd3,
    MEM_CODE_OUT_OF_BOUNDS = 3'd4
  } mem_code_e;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    mem_code_e         code;
  } mem_res_t;

  localparam mem_res_t RES_NONE = '{data: '0, code: MEM_CODE_INVALID};

  function automatic logic [WORD_W-1:0] lane_bits(
    input logic [LANE_N-1:0] be
  );
    for (int i = 0; i < LANE_N; i++)
      lane_bits[i*8 +: 8] = {8{be[i]}};
  endfunction

endpackage

// File: rtl/mem_lane_select.sv
// Byte-lane steering: write enables/alignment and read extraction.
// Purely combinational; offset is the low two address bits.
module mem_lane_select
  import csr_bank_pkg::*;
(
  input  logic [MEM_COUNT_W-1:0] count,
  input  logic [1:0]             offset,
  input  logic [WORD_W-1:0]      wr_data,
  input  logic [WORD_W-1:0]      rd_word,
  output logic [WORD_W-1:0]      wr_mask,
  output logic [WORD_W-1:0]      wr_lane,
  output logic [WORD_W-1:0]      rd_data
);

  logic [4:0]        sh;
  logic [LANE_N-1:0] be;
  logic [WORD_W-1:0] rd_sh;

  assign sh      = {offset, 3'b000};
  assign rd_sh   = rd_word >> sh;
  assign wr_lane = wr_data << sh;
  assign wr_mask = lane_bits(be);

  always_comb begin
    be      = '0;
    rd_data = '0;
    unique case (1'b1)
      count == MEM_COUNT_BYTE: begin
        be      = 4'b0001 << offset;
        rd_data = {24'b0, rd_sh[7:0]};
      end
      count == MEM_COUNT_HALF: begin
        be      = 4'b0011 << offset;
        rd_data = {16'b0, rd_sh[15:0]};
      end
      count == MEM_COUNT_WORD: begin
        be      = 4'b1111;
        rd_data = rd_sh;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/csr_bank.sv
// Control/status register bank with RW, RO-status and W1C sticky words,
// hardware set inputs, interrupt output and 1- or 2-cycle read latency.
module csr_bank
  import csr_bank_pkg::*;
#(
  parameter logic [ADDR_W-1:0]             ADDR_START  = '0,
  parameter int                            WORD_COUNT  = 4,
  parameter logic [WORD_COUNT-1:0]         RO_MASK     = '0,
  parameter logic [WORD_COUNT-1:0]         W1C_MASK    = '0,
  parameter logic [WORD_W*WORD_COUNT-1:0]  RESET_VALUE = '0,
  parameter int                            RD_LATENCY  = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ADDR_W-1:0]             i_req_addr,
  input  logic [WORD_W-1:0]             i_req_wr_data,
  input  logic                          i_req_wr_en,
  input  logic [MEM_COUNT_W-1:0]        i_req_count,
  input  logic [WORD_W*WORD_COUNT-1:0]  i_status,
  input  logic [WORD_W*WORD_COUNT-1:0]  i_hw_set,
  output logic [WORD_W-1:0]             o_res_rd_data,
  output logic [MEM_CODE_W-1:0]         o_res_code,
  output logic [WORD_W*WORD_COUNT-1:0]  o_exposed_mem,
  output logic                          o_irq
);

  localparam int MW    = WORD_W * WORD_COUNT;
  localparam int IDX_W = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
  localparam logic [ADDR_W:0] LAST =
    {1'b0, ADDR_START} + (ADDR_W+1)'(4*WORD_COUNT - 1);

  logic [MW-1:0]     mem_q, mem_d, w1c_bits;
  logic [IDX_W-1:0]  idx;
  logic              req, misaligned, in_range, wr_hit;
  logic [WORD_W-1:0] rd_word, rd_data, wr_mask, wr_lane;
  mem_res_t          res_d, res_q1, res_out;

  assign req = i_req_count != MEM_COUNT_NONE;
  assign misaligned =
    (i_req_count == MEM_COUNT_HALF && i_req_addr[0]) ||
    (i_req_count == MEM_COUNT_WORD && i_req_addr[1:0] != 2'b00);
  assign in_range = (i_req_addr >= ADDR_START) &&
                    ({1'b0, i_req_addr} <= LAST);
  assign idx = IDX_W'((i_req_addr - ADDR_START) >> 2);

  for (genvar j = 0; j < WORD_COUNT; j++) begin : g_word
    assign w1c_bits[j*WORD_W +: WORD_W] = {WORD_W{W1C_MASK[j]}};
    assign o_exposed_mem[j*WORD_W +: WORD_W] =
      RO_MASK[j] ? '0 : mem_q[j*WORD_W +: WORD_W];
  end

  mem_lane_select u_lane (
    .count   (i_req_count),
    .offset  (i_req_addr[1:0]),
    .wr_data (i_req_wr_data),
    .rd_word (rd_word),
    .wr_mask (wr_mask),
    .wr_lane (wr_lane),
    .rd_data (rd_data)
  );

  // RO words read the live status input, never the stored copy.
  always_comb begin
    rd_word = '0;
    for (int j = 0; j < WORD_COUNT; j++)
      if (idx == IDX_W'(j))
        rd_word = RO_MASK[j] ? i_status[j*WORD_W +: WORD_W]
                             : mem_q[j*WORD_W +: WORD_W];
  end

  always_comb begin
    res_d  = RES_NONE;
    wr_hit = 1'b0;
    if (req) begin
      if (misaligned)
        res_d.code = MEM_CODE_MISALIGNED;
      else if (!in_range)
        res_d.code = MEM_CODE_OUT_OF_BOUNDS;
      else if (i_req_wr_en) begin
        res_d.code = MEM_CODE_WRITE;
        wr_hit     = 1'b1;
      end else begin
        res_d.code = MEM_CODE_READ;
        res_d.data = rd_data;
      end
    end
  end

  // Hardware set is OR-ed last so it wins over a same-cycle clear.
  always_comb begin
    mem_d = mem_q;
    for (int j = 0; j < WORD_COUNT; j++) begin
      if (RO_MASK[j])
        mem_d[j*WORD_W +: WORD_W] = '0;
      else if (W1C_MASK[j])
        mem_d[j*WORD_W +: WORD_W] =
          (mem_q[j*WORD_W +: WORD_W] &
           ~((wr_hit && idx == IDX_W'(j)) ? (wr_lane & wr_mask) : '0)) |
          i_hw_set[j*WORD_W +: WORD_W];
      else if (wr_hit && idx == IDX_W'(j))
        mem_d[j*WORD_W +: WORD_W] =
          (mem_q[j*WORD_W +: WORD_W] & ~wr_mask) | (wr_lane & wr_mask);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q  <= RESET_VALUE;
      res_q1 <= RES_NONE;
      o_irq  <= 1'b0;
    end else begin
      mem_q  <= mem_d;
      res_q1 <= res_d;
      o_irq  <= |(mem_q & w1c_bits);
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    mem_res_t res_q2;
    always_ff @(posedge clk) begin
      if (reset) res_q2 <= RES_NONE;
      else       res_q2 <= res_q1;
    end
    assign res_out = res_q2;
  end else begin : g_lat1
    assign res_out = res_q1;
  end

  assign o_res_rd_data = res_out.data;
  assign o_res_code    = res_out.code;

endmodule

// File: tb/tb_csr_bank.sv
// Bench for csr_bank: latency-1 and latency-2 instances share stimulus;
// a byte-addressed model checks every cycle, plus literal spot checks.
module tb_csr_bank;
  import csr_bank_pkg::*;

  localparam int WC = 4;
  localparam int MW = WORD_W * WC;
  localparam logic [MW-1:0] RV = {32'hDEADBEEF, 96'h0};

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [31:0]       a = '0, wd = '0;
  logic              we = 1'b0;
  logic [1:0]        cnt = MEM_COUNT_NONE;
  logic [MW-1:0]     status = '0, hw = '0;
  logic [31:0]       d1, d2;
  logic [2:0]        c1, c2;
  logic [MW-1:0]     x1, x2;
  logic              q1, q2;
  int                total = 0, bad = 0;

  always #5 clk = ~clk;

  csr_bank #(
    .ADDR_START(32'h100), .WORD_COUNT(WC), .RO_MASK(4'b0010),
    .W1C_MASK(4'b0100), .RESET_VALUE(RV), .RD_LATENCY(1)
  ) u_lat1 (
    .clk(clk), .reset(reset), .i_req_addr(a), .i_req_wr_data(wd),
    .i_req_wr_en(we), .i_req_count(cnt), .i_status(status),
    .i_hw_set(hw), .o_res_rd_data(d1), .o_res_code(c1),
    .o_exposed_mem(x1), .o_irq(q1)
  );

  csr_bank #(
    .ADDR_START(32'h100), .WORD_COUNT(WC), .RO_MASK(4'b0010),
    .W1C_MASK(4'b0100), .RESET_VALUE(RV), .RD_LATENCY(2)
  ) u_lat2 (
    .clk(clk), .reset(reset), .i_req_addr(a), .i_req_wr_data(wd),
    .i_req_wr_en(we), .i_req_count(cnt), .i_status(status),
    .i_hw_set(hw), .o_res_rd_data(d2), .o_res_code(c2),
    .o_exposed_mem(x2), .o_irq(q2)
  );

  task automatic chk(input string name, input logic [MW-1:0] act,
                     input logic [MW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Model: 16 bytes of storage; word 1 is status, word 2 is sticky.
  logic [7:0]  mb [16];
  logic [31:0] e1_d = '0, e2_d = '0;
  logic [2:0]  e1_c = MEM_CODE_INVALID, e2_c = MEM_CODE_INVALID;
  logic        e_irq = 1'b0;
  bit          started = 1'b0;

  always @(posedge clk) begin
    int n;
    int off;
    logic [7:0] b;
    started = 1'b1;
    if (reset) begin
      for (int k = 0; k < 16; k++) mb[k] = RV[8*k +: 8];
      e1_d = '0; e1_c = MEM_CODE_INVALID;
      e2_d = '0; e2_c = MEM_CODE_INVALID;
      e_irq = 1'b0;
    end else begin
      e_irq = (mb[8] | mb[9] | mb[10] | mb[11]) != 8'h00;
      e2_d = e1_d; e2_c = e1_c;
      e1_d = '0;   e1_c = MEM_CODE_INVALID;
      n = (cnt == MEM_COUNT_BYTE) ? 1 : (cnt == MEM_COUNT_HALF) ? 2 :
          (cnt == MEM_COUNT_WORD) ? 4 : 0;
      if (n != 0) begin
        if ((a % n) != 0)
          e1_c = MEM_CODE_MISALIGNED;
        else if (a < 32'h100 || a > 32'h10F)
          e1_c = MEM_CODE_OUT_OF_BOUNDS;
        else begin
          off = int'(a - 32'h100);
          if (we) begin
            e1_c = MEM_CODE_WRITE;
            for (int k = 0; k < n; k++) begin
              b = wd[8*k +: 8];
              if (off / 4 == 2) mb[off+k] = mb[off+k] & ~b;
              else if (off / 4 != 1) mb[off+k] = b;
            end
          end else begin
            e1_c = MEM_CODE_READ;
            for (int k = 0; k < n; k++)
              e1_d[8*k +: 8] = (off / 4 == 1) ?
                status[8*(off+k) +: 8] : mb[off+k];
          end
        end
      end
      for (int k = 8; k < 12; k++) mb[k] = mb[k] | hw[8*k +: 8];
    end
  end

  always @(negedge clk) begin
    logic [MW-1:0] ex;
    if (started) begin
      for (int k = 0; k < 16; k++) ex[8*k +: 8] = mb[k];
      chk("cyc_lat1_data", MW'(d1), MW'(e1_d));
      chk("cyc_lat1_code", MW'(c1), MW'(e1_c));
      chk("cyc_lat2_data", MW'(d2), MW'(e2_d));
      chk("cyc_lat2_code", MW'(c2), MW'(e2_c));
      chk("cyc_irq1", MW'(q1), MW'(e_irq));
      chk("cyc_irq2", MW'(q2), MW'(e_irq));
      chk("cyc_mem1", x1, ex);
      chk("cyc_mem2", x2, ex);
    end
  end

  task automatic req(input logic [31:0] ad, input logic [31:0] dat,
                     input logic w, input logic [1:0] c,
                     input logic [MW-1:0] h);
    a = ad; wd = dat; we = w; cnt = c; hw = h;
    @(posedge clk);
    @(negedge clk);
    a = '0; wd = '0; we = 1'b0; cnt = MEM_COUNT_NONE; hw = '0;
  endtask

  task automatic idle();
    req(32'h0, 32'h0, 1'b0, MEM_COUNT_NONE, '0);
  endtask

  initial begin
    logic [MW-1:0] h;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_code", MW'(c1), MW'(MEM_CODE_INVALID));
    chk("rst_data", MW'(d1), '0);
    chk("rst_irq", MW'(q1), '0);
    chk("rst_word3", MW'(x1[127:96]), MW'(32'hDEADBEEF));

    req(32'h10C, 32'h0, 1'b0, MEM_COUNT_WORD, '0);
    chk("rd_reset_val", MW'(d1), MW'(32'hDEADBEEF));
    chk("rd_reset_code", MW'(c1), MW'(MEM_CODE_READ));

    req(32'h101, 32'hAB, 1'b1, MEM_COUNT_BYTE, '0);
    chk("byte_wr_code", MW'(c1), MW'(MEM_CODE_WRITE));
    req(32'h100, 32'h0, 1'b0, MEM_COUNT_HALF, '0);
    chk("half_rd_data", MW'(d1), MW'(32'h0000AB00));
    req(32'h101, 32'h0, 1'b0, MEM_COUNT_HALF, '0);
    chk("half_misalign", MW'(c1), MW'(MEM_CODE_MISALIGNED));
    chk("half_misalign_d", MW'(d1), '0);
    req(32'h110, 32'h0, 1'b0, MEM_COUNT_WORD, '0);
    chk("oob_high", MW'(c1), MW'(MEM_CODE_OUT_OF_BOUNDS));
    req(32'h0FC, 32'h0, 1'b0, MEM_COUNT_WORD, '0);
    chk("oob_low", MW'(c1), MW'(MEM_CODE_OUT_OF_BOUNDS));

    status[63:32] = 32'h12345678;
    req(32'h104, 32'hFFFFFFFF, 1'b1, MEM_COUNT_WORD, '0);
    chk("ro_wr_code", MW'(c1), MW'(MEM_CODE_WRITE));
    req(32'h104, 32'h0, 1'b0, MEM_COUNT_WORD, '0);
    chk("ro_rd_data", MW'(d1), MW'(32'h12345678));
    chk("ro_exposed", MW'(x1[63:32]), '0);
    req(32'h106, 32'h0, 1'b0, MEM_COUNT_BYTE, '0);
    chk("ro_byte_rd", MW'(d1), MW'(32'h34));

    h = '0; h[95:64] = 32'h5;
    req(32'h0, 32'h0, 1'b0, MEM_COUNT_NONE, h);
    chk("irq_lag", MW'(q1), '0);
    req(32'h108, 32'h01, 1'b1, MEM_COUNT_BYTE, '0);
    chk("irq_set", MW'(q1), MW'(1'b1));
    chk("w1c_clr1", MW'(x1[95:64]), MW'(32'h4));
    req(32'h108, 32'h04, 1'b1, MEM_COUNT_BYTE, '0);
    chk("irq_hold", MW'(q1), MW'(1'b1));
    chk("w1c_clr2", MW'(x1[95:64]), '0);
    idle();
    chk("irq_drop", MW'(q1), '0);

    h = '0; h[95:64] = 32'h1;
    req(32'h0, 32'h0, 1'b0, MEM_COUNT_NONE, h);
    req(32'h108, 32'h1, 1'b1, MEM_COUNT_BYTE, h);
    chk("set_wins", MW'(x1[95:64]), MW'(32'h1));
    h = '0; h[95:64] = 32'h2;
    req(32'h108, 32'h0, 1'b0, MEM_COUNT_WORD, h);
    chk("rd_old_val", MW'(d1), MW'(32'h1));
    chk("set_after_rd", MW'(x1[95:64]), MW'(32'h3));

    req(32'h100, 32'hCAFEF00D, 1'b1, MEM_COUNT_WORD, '0);
    chk("b2b_wr_lat1", MW'(c1), MW'(MEM_CODE_WRITE));
    req(32'h100, 32'h0, 1'b0, MEM_COUNT_WORD, '0);
    chk("b2b_wr_lat2", MW'(c2), MW'(MEM_CODE_WRITE));
    chk("b2b_rd_lat1", MW'(d1), MW'(32'hCAFEF00D));
    idle();
    chk("b2b_rd_lat2c", MW'(c2), MW'(MEM_CODE_READ));
    chk("b2b_rd_lat2d", MW'(d2), MW'(32'hCAFEF00D));

    req(32'h10C, 32'h0, 1'b0, MEM_COUNT_WORD, '0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("flush_rst", MW'(c2), MW'(MEM_CODE_INVALID));
    idle();
    chk("flush_code", MW'(c2), MW'(MEM_CODE_INVALID));
    chk("flush_data", MW'(d2), '0);
    chk("flush_word0", MW'(x1[31:0]), '0);
    chk("flush_word3", MW'(x1[127:96]), MW'(32'hDEADBEEF));
    req(32'h10C, 32'h0, 1'b0, MEM_COUNT_HALF, '0);
    idle();
    chk("post_rst_lat2", MW'(d2), MW'(32'hBEEF));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
